// File: rtl/ram_pkg.sv
// ram_pkg: shared types and constants for the RAM latency controller
package ram_pkg;
  typedef enum logic [1:0] {FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3} ramstate_t;
  typedef logic [31:0] word_t;
  localparam int WORD_BYTES = 4;
endpackage

// File: rtl/ram_latency_ctrl.sv
// ram_latency_ctrl: fixed-latency main-memory emulation in front of a 1-cycle-read SRAM
module ram_latency_ctrl
  import ram_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16384,
  parameter int LAT    = 4
) (
  input  logic                     CLK,
  input  logic                     rst,
  input  logic [ADDR_W-1:0]        memaddr,
  input  logic [DATA_W-1:0]        memstore,
  input  logic                     memREN,
  input  logic                     memWEN,
  output logic [DATA_W-1:0]        ramload,
  output ramstate_t                ramstate,
  output logic [$clog2(DEPTH)-1:0] sram_addr,
  output logic [DATA_W-1:0]        sram_wdata,
  output logic                     sram_ren,
  output logic                     sram_wen,
  input  logic [DATA_W-1:0]        sram_rdata
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(LAT) + 1;
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(DEPTH * WORD_BYTES);
  if (LAT < 1) begin : g_lat_chk
    $error("LAT must be at least 1");
  end
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_ACCESS, S_ERR} st_t;
  st_t state, state_n;
  logic [AW-1:0] a_q, a_n;
  logic [DATA_W-1:0] d_q, d_n, rdata_q;
  logic wr_q, wr_n;
  logic [CW-1:0] cnt, cnt_n;
  logic req, bad, diff, rd_acc;
  assign req = memREN | memWEN;
  assign bad = (memREN & memWEN) | (memaddr[1:0] != 2'b00) | ({1'b0, memaddr} >= LIMIT);
  // only meaningful for a good request, so the word index alone identifies the address
  assign diff = (memaddr[AW+1:2] != a_q) | (memWEN != wr_q) | (memWEN & (memstore != d_q));
  assign rd_acc = (state == S_ACCESS) & !wr_q;
  always_comb begin
    state_n = state;
    a_n = a_q;
    d_n = d_q;
    wr_n = wr_q;
    cnt_n = cnt;
    case (state)
      S_IDLE: if (req) begin
        state_n = bad ? S_ERR : S_BUSY;
        if (!bad) begin
          a_n = memaddr[AW+1:2];
          d_n = memstore;
          wr_n = memWEN;
          cnt_n = CW'(LAT - 1);
        end
      end
      S_BUSY: if (!req) state_n = S_IDLE;
      else if (bad) state_n = S_ERR;
      else if (diff) begin
        a_n = memaddr[AW+1:2];
        d_n = memstore;
        wr_n = memWEN;
        cnt_n = CW'(LAT - 1);
      end
      else if (cnt == '0) state_n = S_ACCESS;
      else cnt_n = cnt - 1'b1;
      S_ACCESS: state_n = S_IDLE;
      default: state_n = req ? S_ERR : S_IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (rst) begin
      state <= S_IDLE;
      a_q <= '0;
      d_q <= '0;
      wr_q <= 1'b0;
      cnt <= '0;
      rdata_q <= '0;
    end else begin
      state <= state_n;
      a_q <= a_n;
      d_q <= d_n;
      wr_q <= wr_n;
      cnt <= cnt_n;
      rdata_q <= rd_acc ? sram_rdata : rdata_q;
    end
  end
  assign ramstate = state == S_IDLE ? FREE : state == S_BUSY ? BUSY : state == S_ACCESS ? ACCESS : ERROR;
  assign ramload = rd_acc ? sram_rdata : rdata_q;
  assign sram_addr = a_q;
  assign sram_wdata = d_q;
  assign sram_ren = !rst & (state == S_BUSY) & (state_n == S_ACCESS) & !wr_q;
  assign sram_wen = !rst & (state == S_ACCESS) & wr_q;
endmodule

// File: tb/tb_ram_latency_ctrl.sv
// tb_ram_latency_ctrl: directed vector bench with behavioural SRAM models
module tb_ram_latency_ctrl;
  import ram_pkg::*;
  typedef struct {
    logic ren, wen;
    logic [31:0] addr, data;
    ramstate_t st;
    logic sren, swen;
    logic [13:0] sa;
    logic lc;
    logic [31:0] load;
  } vec_t;
  logic clk = 1'b0;
  logic rst;
  logic ren, wen;
  logic [31:0] addr, wdata;
  logic [31:0] ramload, sram_wdata, sram_rdata;
  ramstate_t ramstate;
  logic [13:0] sram_addr;
  logic sram_ren, sram_wen;
  logic ren1;
  logic [31:0] load1, swd1, srd1;
  ramstate_t st1;
  logic [5:0] saddr1;
  logic sren1, swen1;
  logic [31:0] mem [16384];
  logic [31:0] mem1 [64];
  int nvec = 0;
  int nerr = 0;
  vec_t tbl[$];
  vec_t v;
  always #5 clk = ~clk;
  ram_latency_ctrl #(.ADDR_W(32), .DATA_W(32), .DEPTH(16384), .LAT(4)) u0 (
    .CLK(clk), .rst(rst), .memaddr(addr), .memstore(wdata), .memREN(ren), .memWEN(wen),
    .ramload(ramload), .ramstate(ramstate), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_ren(sram_ren), .sram_wen(sram_wen), .sram_rdata(sram_rdata)
  );
  ram_latency_ctrl #(.ADDR_W(32), .DATA_W(32), .DEPTH(64), .LAT(1)) u1 (
    .CLK(clk), .rst(rst), .memaddr(32'h0), .memstore(32'h0), .memREN(ren1), .memWEN(1'b0),
    .ramload(load1), .ramstate(st1), .sram_addr(saddr1), .sram_wdata(swd1),
    .sram_ren(sren1), .sram_wen(swen1), .sram_rdata(srd1)
  );
  always @(posedge clk) begin
    if (sram_wen) mem[sram_addr] <= sram_wdata;
    if (sram_ren) sram_rdata <= mem[sram_addr];
    if (swen1) mem1[saddr1] <= swd1;
    if (sren1) srd1 <= mem1[saddr1];
  end
  function automatic vec_t mk(logic r, logic w, logic [31:0] a, logic [31:0] d, ramstate_t s,
                              logic sr, logic sw, logic [13:0] sa, logic lc, logic [31:0] l);
    vec_t x;
    x.ren = r; x.wen = w; x.addr = a; x.data = d; x.st = s;
    x.sren = sr; x.swen = sw; x.sa = sa; x.lc = lc; x.load = l;
    return x;
  endfunction
  task automatic add(input int n, input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                     input ramstate_t s, input logic sr, input logic sw, input logic [13:0] sa, input logic [31:0] l);
    for (int i = 0; i < n; i++) tbl.push_back(mk(r, w, a, d, s, sr, sw, sa, 1'b1, l));
  endtask
  task automatic drive(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    @(posedge clk);
    #1;
    ren = r; wen = w; addr = a; wdata = d;
    #3;
  endtask
  task automatic check(input string nm, input vec_t e, input ramstate_t s, input logic r, input logic w,
                       input logic [13:0] a, input logic [31:0] l);
    logic [49:0] act, exp;
    act = {s, r, w, (e.sren | e.swen) ? a : 14'h0, e.lc ? l : 32'h0};
    exp = {e.st, e.sren, e.swen, e.sa, e.lc ? e.load : 32'h0};
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got st=%0d ren=%b wen=%b addr=%h load=%h, want st=%0d ren=%b wen=%b addr=%h load=%h",
               nm, s, r, w, a, l, e.st, e.sren, e.swen, e.sa, e.load);
    end
  endtask
  task automatic apply(input string nm, input vec_t e);
    drive(e.ren, e.wen, e.addr, e.data);
    check(nm, e, ramstate, sram_ren, sram_wen, sram_addr, ramload);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  initial begin
    rst = 1'b1; ren = 1'b0; wen = 1'b0; addr = '0; wdata = '0; ren1 = 1'b0;
    mem[16'h20] = 32'hCAFE0020;
    mem[16'h41] = 32'h0BADF00D;
    mem[16'h18] = 32'h22222222;
    mem[16'h00] = 32'hA5A50000;
    mem1[0] = 32'h5A5A0001;
    add(1, 0, 1, 32'h40, 32'hDEADBEEF, FREE, 0, 0, 14'h0, 32'h0);
    add(4, 0, 1, 32'h40, 32'hDEADBEEF, BUSY, 0, 0, 14'h0, 32'h0);
    add(1, 0, 0, 32'h0, 32'h0, ACCESS, 0, 1, 14'h10, 32'h0);
    add(1, 0, 0, 32'h0, 32'h0, FREE, 0, 0, 14'h0, 32'h0);
    add(1, 1, 0, 32'h40, 32'h0, FREE, 0, 0, 14'h0, 32'h0);
    add(3, 1, 0, 32'h40, 32'h0, BUSY, 0, 0, 14'h0, 32'h0);
    add(1, 1, 0, 32'h40, 32'h0, BUSY, 1, 0, 14'h10, 32'h0);
    add(1, 1, 0, 32'h40, 32'h0, ACCESS, 0, 0, 14'h0, 32'hDEADBEEF);
    add(2, 0, 0, 32'h0, 32'h0, FREE, 0, 0, 14'h0, 32'hDEADBEEF);
    add(1, 1, 1, 32'h0, 32'h0, FREE, 0, 0, 14'h0, 32'hDEADBEEF);
    add(1, 1, 1, 32'h0, 32'h0, ERROR, 0, 0, 14'h0, 32'hDEADBEEF);
    add(1, 1, 0, 32'h0, 32'h0, ERROR, 0, 0, 14'h0, 32'hDEADBEEF);
    add(1, 0, 0, 32'h0, 32'h0, ERROR, 0, 0, 14'h0, 32'hDEADBEEF);
    add(1, 0, 0, 32'h0, 32'h0, FREE, 0, 0, 14'h0, 32'hDEADBEEF);
    add(1, 1, 0, 32'h3, 32'h0, FREE, 0, 0, 14'h0, 32'hDEADBEEF);
    add(1, 0, 0, 32'h0, 32'h0, ERROR, 0, 0, 14'h0, 32'hDEADBEEF);
    add(1, 0, 0, 32'h0, 32'h0, FREE, 0, 0, 14'h0, 32'hDEADBEEF);
    add(1, 0, 1, 32'h10000, 32'h0, FREE, 0, 0, 14'h0, 32'hDEADBEEF);
    add(1, 0, 0, 32'h0, 32'h0, ERROR, 0, 0, 14'h0, 32'hDEADBEEF);
    add(1, 0, 0, 32'h0, 32'h0, FREE, 0, 0, 14'h0, 32'hDEADBEEF);
    add(1, 0, 1, 32'h80, 32'h12345678, FREE, 0, 0, 14'h0, 32'hDEADBEEF);
    add(1, 0, 1, 32'h80, 32'h12345678, BUSY, 0, 0, 14'h0, 32'hDEADBEEF);
    add(1, 0, 0, 32'h0, 32'h0, BUSY, 0, 0, 14'h0, 32'hDEADBEEF);
    add(1, 0, 0, 32'h0, 32'h0, FREE, 0, 0, 14'h0, 32'hDEADBEEF);
    add(1, 1, 0, 32'h80, 32'h0, FREE, 0, 0, 14'h0, 32'hDEADBEEF);
    add(3, 1, 0, 32'h80, 32'h0, BUSY, 0, 0, 14'h0, 32'hDEADBEEF);
    add(1, 1, 0, 32'h80, 32'h0, BUSY, 1, 0, 14'h20, 32'hDEADBEEF);
    add(1, 0, 0, 32'h0, 32'h0, ACCESS, 0, 0, 14'h0, 32'hCAFE0020);
    add(1, 0, 0, 32'h0, 32'h0, FREE, 0, 0, 14'h0, 32'hCAFE0020);
    add(1, 1, 0, 32'h44, 32'h0, FREE, 0, 0, 14'h0, 32'hCAFE0020);
    add(1, 1, 0, 32'h44, 32'h0, BUSY, 0, 0, 14'h0, 32'hCAFE0020);
    add(1, 1, 1, 32'h44, 32'h0, BUSY, 0, 0, 14'h0, 32'hCAFE0020);
    add(1, 0, 0, 32'h0, 32'h0, ERROR, 0, 0, 14'h0, 32'hCAFE0020);
    add(1, 0, 0, 32'h0, 32'h0, FREE, 0, 0, 14'h0, 32'hCAFE0020);
    repeat (2) drive(0, 0, 32'h0, 32'h0);
    rst = 1'b0;
    for (int i = 0; i < tbl.size(); i++) apply($sformatf("vec%0d", i), tbl[i]);
    // restart: address changes two cycles in, so the full latency starts over
    for (int t = 0; t <= 8; t++) begin
      v = mk(t <= 7, 1'b0, t < 2 ? 32'h100 : 32'h104, 32'h0,
             t == 0 ? FREE : t <= 6 ? BUSY : t == 7 ? ACCESS : FREE,
             t == 6, 1'b0, t == 6 ? 14'h41 : 14'h0, t >= 7, 32'h0BADF00D);
      apply($sformatf("restart_t%0d", t), v);
    end
    apply("rstbusy_t0", mk(1, 0, 32'h40, 32'h0, FREE, 0, 0, 14'h0, 1, 32'h0BADF00D));
    apply("rstbusy_t1", mk(1, 0, 32'h40, 32'h0, BUSY, 0, 0, 14'h0, 1, 32'h0BADF00D));
    apply("rstbusy_t2", mk(1, 0, 32'h40, 32'h0, BUSY, 0, 0, 14'h0, 1, 32'h0BADF00D));
    rst = 1'b1;
    repeat (3) drive(0, 0, 32'h0, 32'h0);
    rst = 1'b0;
    apply("rstbusy_release", mk(0, 0, 32'h0, 32'h0, FREE, 0, 0, 14'h0, 1, 32'h0));
    apply("rstwr_t0", mk(0, 1, 32'h60, 32'h11111111, FREE, 0, 0, 14'h0, 1, 32'h0));
    for (int t = 1; t <= 4; t++)
      apply($sformatf("rstwr_t%0d", t), mk(0, 1, 32'h60, 32'h11111111, BUSY, 0, 0, 14'h0, 1, 32'h0));
    @(posedge clk);
    #1;
    rst = 1'b1; wen = 1'b0;
    #3;
    check("rstwr_access", mk(0, 0, 32'h0, 32'h0, ACCESS, 0, 0, 14'h0, 0, 32'h0),
          ramstate, sram_ren, sram_wen, sram_addr, ramload);
    drive(0, 0, 32'h0, 32'h0);
    rst = 1'b0;
    apply("rstwr_release", mk(0, 0, 32'h0, 32'h0, FREE, 0, 0, 14'h0, 1, 32'h0));
    nvec++;
    if (mem[16'h18] !== 32'h22222222) begin
      nerr++;
      $display("FAIL rstwr_mem: got %h, want %h", mem[16'h18], 32'h22222222);
    end
    for (int k = 0; k < 18; k++) begin
      v = mk(1, 0, 32'h0, 32'h0, k % 6 == 0 ? FREE : k % 6 == 5 ? ACCESS : BUSY,
             k % 6 == 4, 1'b0, 14'h0, k % 6 == 5, 32'hA5A50000);
      apply($sformatf("b2b_lat4_k%0d", k), v);
    end
    drive(0, 0, 32'h0, 32'h0);
    for (int k = 0; k < 9; k++) begin
      @(posedge clk);
      #1;
      ren1 = 1'b1;
      #3;
      v = mk(1, 0, 32'h0, 32'h0, k % 3 == 0 ? FREE : k % 3 == 1 ? BUSY : ACCESS,
             k % 3 == 1, 1'b0, 14'h0, k % 3 == 2, 32'h5A5A0001);
      check($sformatf("b2b_lat1_k%0d", k), v, st1, sren1, swen1, {8'h0, saddr1}, load1);
    end
    ren1 = 1'b0;
    drive(0, 0, 32'h0, 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
